// File: rtl/debug_tx_sequencer.sv
`timescale 1ns/1ps
// Debug frame sequencer: snapshots PC/count, walks regfile then data memory, serializes each word MSB-first.
// Latency: first tx strobe 3 cycles after accept; next byte 1 cycle after tx done, next word 3 cycles after.
// Backpressure: every byte waits for i_tx_done; send requests while busy are dropped, never queued.

module debug_tx_sequencer #(
  parameter int NUM_REGS      = 32,
  parameter int NUM_MEM_WORDS = 16,
  parameter int MEM_ADDR_W    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start_send,
  input  logic [31:0]           i_pc,
  input  logic [31:0]           i_clk_count,
  output logic [4:0]            o_reg_addr,
  input  logic [31:0]           i_reg_data,
  output logic [MEM_ADDR_W-1:0] o_mem_addr,
  input  logic [31:0]           i_mem_data,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_start,
  input  logic                  i_tx_done,
  output logic                  o_busy,
  output logic                  o_done_send
);

  // Frame layout: word 0 = PC, word 1 = count, then registers, then memory.
  localparam logic [7:0] REG_FIRST = 8'd2;
  localparam logic [7:0] MEM_FIRST = 8'(2 + NUM_REGS);
  localparam logic [7:0] LAST_WORD = 8'(1 + NUM_REGS + NUM_MEM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LOAD,
    S_SEND,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [31:0]             pc_snap;
  logic [31:0]             cnt_snap;
  logic [31:0]             shift_reg;
  logic [31:0]             load_word;
  logic [7:0]              word_idx;
  logic [7:0]              word_inc;
  logic [1:0]              byte_idx;
  logic [4:0]              reg_addr_nxt;
  logic [MEM_ADDR_W-1:0]   mem_addr_nxt;
  logic                    last_byte;
  logic                    last_word;

  assign word_inc  = word_idx + 8'd1;
  assign last_byte = (byte_idx == 2'd3);
  assign last_word = (word_idx >= LAST_WORD);
  assign o_tx_data = shift_reg[31:24];

  // Addresses for the next word, registered when the word index advances so they are valid during ADDR.
  always_comb begin
    reg_addr_nxt = '0;
    mem_addr_nxt = '0;
    if (word_inc >= REG_FIRST && word_inc < MEM_FIRST)
      reg_addr_nxt = 5'(word_inc - REG_FIRST);
    if (word_inc >= MEM_FIRST && word_inc <= LAST_WORD)
      mem_addr_nxt = MEM_ADDR_W'(word_inc - MEM_FIRST);
  end

  // Pick the source for the current word: snapshots first, then register file, then memory.
  always_comb begin
    load_word = i_mem_data;
    if (word_idx == 8'd0)
      load_word = pc_snap;
    else if (word_idx == 8'd1)
      load_word = cnt_snap;
    else if (word_idx < MEM_FIRST)
      load_word = i_reg_data;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state decode and strobes derived from the current state.
  always_comb begin
    state_nxt   = state;
    o_tx_start  = 1'b0;
    o_done_send = 1'b0;
    o_busy      = (state != S_IDLE);
    case (state)
      S_IDLE: if (i_start_send) state_nxt = S_ADDR;
      S_ADDR: state_nxt = S_LOAD;
      S_LOAD: state_nxt = S_SEND;
      S_SEND: begin
        o_tx_start = 1'b1;
        state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        if (i_tx_done) begin
          if (!last_byte)
            state_nxt = S_SEND;
          else if (!last_word)
            state_nxt = S_ADDR;
          else
            state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        o_done_send = 1'b1;
        state_nxt   = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: snapshots at accept, word load, byte shifting and index/address advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_snap    <= '0;
      cnt_snap   <= '0;
      shift_reg  <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      o_reg_addr <= '0;
      o_mem_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start_send) begin
            pc_snap    <= i_pc;
            cnt_snap   <= i_clk_count;
            word_idx   <= '0;
            byte_idx   <= '0;
            o_reg_addr <= '0;
            o_mem_addr <= '0;
          end
        end
        S_LOAD: shift_reg <= load_word;
        S_WAIT: begin
          if (i_tx_done) begin
            if (!last_byte) begin
              shift_reg <= {shift_reg[23:0], 8'h00};
              byte_idx  <= byte_idx + 2'd1;
            end else if (!last_word) begin
              word_idx   <= word_inc;
              byte_idx   <= '0;
              o_reg_addr <= reg_addr_nxt;
              o_mem_addr <= mem_addr_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
